// File: rtl/compact_pack_ctrl_pkg.sv
// Shared definitions for the compact/pack writeback path: precision codes,
// FSM state encoding and the per-precision ratio helpers.
package compact_pack_ctrl_pkg;

  // Three code bits so that out-of-range codes exist and can be flagged.
  localparam int LOG_ALLOWED_PRECISIONS = 3;

  typedef logic [LOG_ALLOWED_PRECISIONS-1:0] prec_t;

  localparam prec_t INT8  = 3'd0;
  localparam prec_t INT16 = 3'd1;
  localparam prec_t INT32 = 3'd2;
  localparam prec_t INT64 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic prec_valid(input prec_t p);
    return (p <= INT64);
  endfunction

  // Number of compacted chunks that fill one output word.
  function automatic logic [3:0] prec_ratio(input prec_t p);
    case (p)
      INT8:    return 4'd8;
      INT16:   return 4'd4;
      INT32:   return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [6:0] prec_bits(input prec_t p);
    case (p)
      INT8:    return 7'd8;
      INT16:   return 7'd16;
      INT32:   return 7'd32;
      default: return 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/compact_pack_ctrl_if.sv
// Input beat stream and packed output word stream of the writeback sequencer.
// Both streams: a transfer happens on a rising clk edge where valid && ready; once
// valid is raised the payload is held stable until that transfer.
interface compact_pack_ctrl_if #(
  parameter int K          = 4,
  parameter int data_width = 64
);
  logic                    s_valid;
  logic                    s_ready;
  logic [K*data_width-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [K*data_width-1:0] m_data;
  logic                    m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/compact_pack_ctrl_compact_and_select.sv
// Combinational lane compaction: keeps the low P bits of each lane and packs
// them contiguously from bit 0, lane 0 lowest. Bits above K*P are zero.
module compact_and_select
  import compact_pack_ctrl_pkg::*;
#(
  parameter int K          = 4,
  parameter int data_width = 64
) (
  input  logic [K*data_width-1:0] data_in,
  input  prec_t                   data_select,
  output logic [K*data_width-1:0] data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < K; i++) begin
      case (data_select)
        INT8:    data_out[i*8  +: 8]  = data_in[i*data_width +: 8];
        INT16:   data_out[i*16 +: 16] = data_in[i*data_width +: 16];
        INT32:   data_out[i*32 +: 32] = data_in[i*data_width +: 32];
        INT64:   data_out[i*64 +: 64] = data_in[i*data_width +: 64];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/compact_pack_ctrl.sv
// Writeback sequencer: compacts each MXU result beat to K P-bit values and packs
// R = 64/P consecutive chunks into one K*data_width output word.
module compact_pack_ctrl
  import compact_pack_ctrl_pkg::*;
#(
  parameter int K          = 4,
  parameter int data_width = 64
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  prec_t                 precision,
  input  logic [15:0]           n_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output state_t                dbg_state,
  compact_pack_ctrl_if.slave    bus
);

  localparam int W = K * data_width;

  state_t          state_q;
  prec_t           prec_q;
  logic [15:0]     n_beats_q;
  logic [15:0]     beat_cnt_q;
  logic [2:0]      slot_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    m_data_q;
  logic            m_valid_q;
  logic            m_last_q;
  logic            busy_q;
  logic            done_q;
  logic            cfg_err_q;

  logic [W-1:0]    chunk;
  logic [W-1:0]    placed;
  logic [15:0]     shift_amt;
  logic [3:0]      ratio;
  logic            s_ready_c;
  logic            accept;
  logic            is_last;
  logic            complete;

  compact_and_select #(.K(K), .data_width(data_width)) u_compact (
    .data_in     (bus.s_data),
    .data_select (prec_q),
    .data_out    (chunk)
  );

  // An un-taken output word blocks intake so a completing beat can never overwrite it.
  assign s_ready_c = (state_q == ST_RUN) && !(m_valid_q && !bus.m_ready);
  assign accept    = bus.s_valid && s_ready_c;
  assign ratio     = prec_ratio(prec_q);
  assign is_last   = (beat_cnt_q == n_beats_q - 16'd1);
  assign complete  = accept && (({1'b0, slot_q} == ratio - 4'd1) || is_last);
  assign shift_amt = 16'(slot_q) * 16'(K) * 16'(prec_bits(prec_q));
  assign placed    = chunk << shift_amt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      prec_q     <= INT8;
      n_beats_q  <= '0;
      beat_cnt_q <= '0;
      slot_q     <= '0;
      acc_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!prec_valid(precision)) begin
              cfg_err_q <= 1'b1;
            end else if (n_beats == 16'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_RUN;
              busy_q     <= 1'b1;
              prec_q     <= precision;
              n_beats_q  <= n_beats;
              beat_cnt_q <= '0;
              slot_q     <= '0;
              acc_q      <= '0;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
            if (complete) begin
              // Accumulator is zero beyond the filled slots, so partial words come out zero-padded.
              m_data_q  <= acc_q | placed;
              m_valid_q <= 1'b1;
              m_last_q  <= is_last;
              acc_q     <= '0;
              slot_q    <= '0;
              if (is_last) state_q <= ST_DRAIN;
            end else begin
              acc_q  <= acc_q | placed;
              slot_q <= slot_q + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (m_valid_q && bus.m_ready && m_last_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_compact_pack_ctrl.sv
// Scoreboard bench for compact_pack_ctrl: a lane/slot placement model fills an
// expected-word queue; a negedge monitor pops and compares every output transfer.
`timescale 1ns/1ps
module tb_compact_pack_ctrl;
  import compact_pack_ctrl_pkg::*;

  localparam int K  = 4;
  localparam int DW = 64;
  localparam int W  = K * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  prec_t       precision = INT8;
  logic [15:0] n_beats = '0;
  logic        busy, done, cfg_err;
  state_t      dbg_state;

  compact_pack_ctrl_if #(.K(K), .data_width(DW)) bus();

  compact_pack_ctrl #(.K(K), .data_width(DW)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .start     (start),
    .precision (precision),
    .n_beats   (n_beats),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W:0]   exp_q[$];
  logic [W-1:0] beat_mem [0:63];
  int           words_seen = 0;
  int           last_hs_cyc = -1;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Word w holds beats w*R .. w*R+R-1; beat j of the word, lane i, lands at
  // element index j*K+i of width P. Anything not covered stays zero.
  task automatic push_expected(input int p_code, input int n);
    int pb, r, words, b;
    logic [W-1:0] word;
    pb = 8 << p_code;
    r  = 64 / pb;
    words = (n + r - 1) / r;
    for (int w = 0; w < words; w++) begin
      word = '0;
      for (int j = 0; j < r; j++) begin
        b = w * r + j;
        if (b < n)
          for (int i = 0; i < K; i++)
            for (int t = 0; t < pb; t++)
              word[(j*K + i)*pb + t] = beat_mem[b][i*DW + t];
      end
      exp_q.push_back({(w == words - 1), word});
    end
  endtask

  task automatic fill_random(input int n);
    for (int b = 0; b < n; b++)
      for (int q = 0; q < W/32; q++) beat_mem[b][q*32 +: 32] = $urandom;
  endtask

  // ---------------- m_ready driver ----------------
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: 5-cycle stall on first word
  bit stall_armed = 1'b0;
  int stall_left = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.m_ready = 1'b1;
      1: bus.m_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (stall_left > 0) begin
          bus.m_ready = 1'b0;
          stall_left--;
        end else if (stall_armed && bus.m_valid) begin
          stall_armed = 1'b0;
          stall_left  = 4;
          bus.m_ready = 1'b0;
        end else begin
          bus.m_ready = 1'b1;
        end
      end
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  bit           held_valid = 1'b0;
  logic [W:0]   held_word;
  logic [W:0]   exp_word;

  always @(negedge clk) begin
    if (!aresetn) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        chk("hold_m_valid", {{W{1'b0}}, bus.m_valid}, {{W{1'b0}}, 1'b1});
        chk("hold_m_data", {bus.m_last, bus.m_data}, held_word);
      end
      if (bus.m_valid && !bus.m_ready) begin
        chk("s_ready_backpressure", {{W{1'b0}}, bus.s_ready}, '0);
        held_valid = 1'b1;
        held_word  = {bus.m_last, bus.m_data};
      end else begin
        held_valid = 1'b0;
      end
      if (bus.m_valid && bus.m_ready) begin
        words_seen++;
        if (bus.m_last) last_hs_cyc = cyc + 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", {bus.m_last, bus.m_data});
        end else begin
          exp_word = exp_q.pop_front();
          chk("word", {bus.m_last, bus.m_data}, exp_word);
        end
      end
    end
  end

  // ---------------- stimulus drivers ----------------
  task automatic start_job(input prec_t p, input logic [15:0] n);
    start = 1'b1;
    precision = p;
    n_beats = n;
    @(posedge clk); #1;
    start = 1'b0;
    if (n != 0) begin
      chk("busy_after_start", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
      chk("state_run", {{(W-1){1'b0}}, dbg_state}, {{(W-1){1'b0}}, ST_RUN});
    end
  endtask

  task automatic send_beats(input int first, input int count, input bit gaps, input int poke_at);
    int tmo;
    for (int b = first; b < first + count; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (b == poke_at) begin
        start = 1'b1;
        precision = prec_t'($urandom_range(0, 3));
        n_beats = 16'd3;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = beat_mem[b];
      tmo = 0;
      forever begin
        @(negedge clk);
        if (bus.s_ready) begin
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        tmo++;
        if (tmo > 500) begin
          checks++;
          errors++;
          $display("FAIL s_ready_timeout: got 0 expected 1 (beat %0d)", b);
          bus.s_valid = 1'b0;
          start = 1'b0;
          return;
        end
      end
      bus.s_valid = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int tmo;
    tmo = 0;
    while (!done && tmo < 3000) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got 0 expected 1", tag);
      return;
    end
    chk({tag, "_done_latency"}, W'(cyc), W'(last_hs_cyc));
    chk({tag, "_busy_at_done"}, {{W{1'b0}}, busy}, '0);
    chk({tag, "_queue_empty"}, W'(exp_q.size()), '0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {{W{1'b0}}, done}, '0);
    chk({tag, "_idle"}, {{(W-1){1'b0}}, dbg_state}, {{(W-1){1'b0}}, ST_IDLE});
  endtask

  task automatic run_job(input string tag, input prec_t p, input int n, input bit gaps, input int poke_at);
    push_expected(int'(p), n);
    start_job(p, 16'(n));
    send_beats(0, n, gaps, poke_at);
    wait_done(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {{(W-5){1'b0}}, busy, done, cfg_err, bus.s_ready, bus.m_valid, bus.m_last},
        '0);
    chk({tag, "_m_data"}, {1'b0, bus.m_data}, '0);
    chk({tag, "_state"}, {{(W-1){1'b0}}, dbg_state}, {{(W-1){1'b0}}, ST_IDLE});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int ws;
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Full-width words pass straight through.
    rdy_mode = 0;
    fill_random(3);
    run_job("int64", INT64, 3, 1'b0, -1);

    // Lane-tagged pattern, two beats per word.
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < K; i++)
        beat_mem[b][i*DW +: DW] = 64'hB000_0000_0000_0000 | 64'(b << 4) | 64'(i);
    run_job("int32", INT32, 4, 1'b0, -1);

    // Partial final word must be zero-padded.
    fill_random(10);
    run_job("int8", INT8, 10, 1'b0, -1);

    // Output stall on the first word.
    rdy_mode = 2;
    stall_armed = 1'b1;
    fill_random(8);
    run_job("int16_bp", INT16, 8, 1'b0, -1);
    chk("stall_taken", {{W{1'b0}}, stall_armed}, '0);
    rdy_mode = 0;

    // Empty job.
    ws = words_seen;
    start_job(INT16, 16'd0);
    chk("empty_done", {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
    chk("empty_busy", {{W{1'b0}}, busy}, '0);
    @(posedge clk); #1;
    chk("empty_done_pulse", {{W{1'b0}}, done}, '0);
    repeat (3) begin @(posedge clk); #1; end
    chk("empty_no_words", W'(words_seen), W'(ws));

    // Undefined precision code.
    start = 1'b1;
    precision = 3'd5;
    n_beats = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_pulse", {{W{1'b0}}, cfg_err}, {{W{1'b0}}, 1'b1});
    chk("cfg_err_busy", {{W{1'b0}}, busy}, '0);
    @(posedge clk); #1;
    chk("cfg_err_clear", {{W{1'b0}}, cfg_err}, '0);
    chk("cfg_err_idle", {{(W-1){1'b0}}, dbg_state}, {{(W-1){1'b0}}, ST_IDLE});

    // Start and config changes during a job are ignored.
    fill_random(6);
    run_job("start_in_run", INT16, 6, 1'b0, 1);

    // Randomized jobs under random output backpressure.
    rdy_mode = 1;
    for (int j = 0; j < 8; j++) begin
      int n;
      prec_t p;
      p = prec_t'($urandom_range(0, 3));
      n = $urandom_range(1, 20);
      fill_random(n);
      run_job("rand", p, n, 1'b1, -1);
    end
    rdy_mode = 0;

    // Reset in the middle of an INT8 job.
    fill_random(8);
    start_job(INT8, 16'd8);
    send_beats(0, 3, 1'b0, -1);
    #3 aresetn = 1'b0;
    #1 check_all_zero("midjob_reset");
    exp_q.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    fill_random(8);
    run_job("after_reset", INT8, 8, 1'b0, -1);

    repeat (5) begin @(posedge clk); #1; end
    chk("final_queue_empty", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
